jc_seq_ctrl: RTL and testbench

JC_SEQ_CTRL -- requirements
Module: jc_seq_ctrl

---
 rtl/jc_pkg.sv | 18 +
 rtl/jc_core.sv | 52 +++++
 rtl/jc_seq_ctrl.sv | 112 +++++++++++
 tb/tb_jc_seq_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/jc_pkg.sv
// Shared types and constants for the Johnson-counter sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package jc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic FWD = 1'b0;
  localparam logic REV = 1'b1;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_STEPW = 8;

endpackage

// File: rtl/jc_core.sv
// Johnson counter with a phase index that tracks the position in the 2*WIDTH cycle.
// Latency: count/phase move one position on the edge where step_en is high.
// Backpressure: none; step_en low simply holds the current position.
module jc_core
  import jc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int PW    = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_en,
  input  logic             dir,
  output logic [WIDTH-1:0] count,
  output logic [PW-1:0]    phase
);

  localparam logic [PW-1:0] PHASE_LAST = PW'(2 * WIDTH - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    phase_q, phase_d;

  // Next position: forward shifts the inverted MSB in at the bottom, reverse undoes it.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (step_en) begin
      if (dir == FWD) begin
        count_d = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
        phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
      end else begin
        count_d = {~count_q[0], count_q[WIDTH-1:1]};
        phase_d = (phase_q == '0) ? PHASE_LAST : phase_q - 1'b1;
      end
    end
  end

  // Position registers; reset parks the counter at all-zeros, phase 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      phase_q <= '0;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign count = count_q;
  assign phase = phase_q;

endmodule

// File: rtl/jc_seq_ctrl.sv
// Runs N-step Johnson-counter commands with pause/abort and a one-cycle done pulse.
// Latency: N-step command accepted at edge 0 steps at edges 1..N, done after N, ready after N+1.
// Backpressure: cmd_ready is low outside IDLE; pause stalls stepping indefinitely.
module jc_seq_ctrl
  import jc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int STEPW = DEFAULT_STEPW
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [STEPW-1:0]              cmd_steps,
  input  logic                          cmd_dir,
  input  logic                          pause,
  input  logic                          abort,
  output logic [WIDTH-1:0]              count,
  output logic [$clog2(2*WIDTH)-1:0]    phase,
  output logic [STEPW-1:0]              steps_left,
  output logic                          busy,
  output logic                          done,
  output logic                          aborted
);

  localparam int PW = $clog2(2 * WIDTH);

  state_t           state_q, state_d;
  logic [STEPW-1:0] steps_left_q, steps_left_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             step_en;

  // Abort wins over pause, and both only matter while a command is running.
  assign step_en   = (state_q == RUN) && !abort && !pause;
  assign cmd_ready = (state_q == IDLE);

  // Next-state, step bookkeeping and registered status flags.
  always_comb begin
    state_d      = state_q;
    steps_left_d = steps_left_q;
    dir_d        = dir_q;
    aborted_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          dir_d        = cmd_dir;
          steps_left_d = cmd_steps;
          state_d      = (cmd_steps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else if (!pause) begin
          steps_left_d = steps_left_q - 1'b1;
          if (steps_left_q == STEPW'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // Controller state; reset drops any command in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      steps_left_q <= '0;
      dir_q        <= FWD;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      steps_left_q <= steps_left_d;
      dir_q        <= dir_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign steps_left = steps_left_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;

  jc_core #(
    .WIDTH (WIDTH),
    .PW    (PW)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .step_en (step_en),
    .dir     (dir_q),
    .count   (count),
    .phase   (phase)
  );

endmodule

// File: tb/tb_jc_seq_ctrl.sv
// Self-checking bench for jc_seq_ctrl: directed scenarios then random traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_jc_seq_ctrl;

  localparam int W  = 4;
  localparam int SW = 8;
  localparam int PW = $clog2(2 * W);

  logic          clk = 1'b0;
  logic          rst, cmd_valid, cmd_dir, pause, abort;
  logic [SW-1:0] cmd_steps;
  logic          cmd_ready, busy, done, aborted;
  logic [W-1:0]  count;
  logic [PW-1:0] phase;
  logic [SW-1:0] steps_left;

  int checks = 0;
  int errors = 0;

  // Reference: position on the 2W ring plus command bookkeeping.
  // mode 0 = waiting for command, 1 = executing, 2 = finishing pulse.
  int m_mode = 0, m_pos = 0, m_left = 0, m_dir = 0, m_ab = 0;

  always #5 clk = ~clk;

  jc_seq_ctrl #(.WIDTH(W), .STEPW(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_steps  (cmd_steps),
    .cmd_dir    (cmd_dir),
    .pause      (pause),
    .abort      (abort),
    .count      (count),
    .phase      (phase),
    .steps_left (steps_left),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  // Johnson pattern at ring position p: p low ones while filling, then ones draining from the bottom.
  function automatic int jc_of(int p);
    if (p <= W) return (1 << p) - 1;
    return ((1 << W) - 1) & ~((1 << (p - W)) - 1);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_mode = 0; m_pos = 0; m_left = 0; m_ab = 0;
    end else if (m_mode == 0) begin
      if (cmd_valid) begin
        m_left = int'(cmd_steps);
        m_dir  = int'(cmd_dir);
        m_ab   = 0;
        m_mode = (m_left == 0) ? 2 : 1;
      end
    end else if (m_mode == 1) begin
      if (abort) begin
        m_mode = 2; m_ab = 1;
      end else if (!pause) begin
        m_pos  = (m_pos + (m_dir ? 2 * W - 1 : 1)) % (2 * W);
        m_left = m_left - 1;
        m_ab   = 0;
        if (m_left == 0) m_mode = 2;
      end
    end else begin
      m_mode = 0;
    end
  endtask

  task automatic check_all();
    check("count",      32'(count),      32'(jc_of(m_pos)));
    check("phase",      32'(phase),      32'(m_pos));
    check("steps_left", 32'(steps_left), 32'(m_left));
    check("cmd_ready",  32'(cmd_ready),  32'(m_mode == 0));
    check("busy",       32'(busy),       32'(m_mode == 1));
    check("done",       32'(done),       32'(m_mode == 2));
    check("aborted",    32'(aborted),    32'(m_mode == 2 && m_ab == 1));
  endtask

  // One clock: apply inputs, advance the reference, then compare after the edge.
  task automatic cyc(input bit v, input int st, input bit d, input bit p, input bit a, input bit r);
    cmd_valid = v; cmd_steps = SW'(st); cmd_dir = d; pause = p; abort = a; rst = r;
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int k;
    int dones;
    logic [W-1:0] fwd_seq [5];
    fwd_seq[0] = 4'b0001; fwd_seq[1] = 4'b0011; fwd_seq[2] = 4'b0111;
    fwd_seq[3] = 4'b1111; fwd_seq[4] = 4'b1110;

    cmd_valid = 0; cmd_steps = '0; cmd_dir = 0; pause = 0; abort = 0; rst = 1;
    #1;

    // Reset
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    check("rst_count", 32'(count), 32'h0);
    check("rst_ready", 32'(cmd_ready), 32'h1);
    cyc(0, 0, 0, 0, 0, 0);

    // Forward 5 with latency
    cyc(1, 5, 0, 0, 0, 0);
    check("fwd_accept_count", 32'(count), 32'h0);
    k = 0; dones = 0;
    while (!cmd_ready && k < 20) begin
      cyc(0, 0, 0, 0, 0, 0);
      k++;
      if (k <= 5) check("fwd_seq", 32'(count), 32'(fwd_seq[k-1]));
      if (done) begin
        dones++;
        check("fwd_aborted", 32'(aborted), 32'h0);
      end
    end
    check("fwd_ready_latency", 32'(k), 32'd6);
    check("fwd_done_pulses", 32'(dones), 32'd1);
    check("fwd_phase", 32'(phase), 32'd5);
    check("fwd_count", 32'(count), 32'b1110);

    // Reverse 7 through the wrap, then forward 10 back to the origin
    cyc(1, 7, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 0);
    check("rev_phase", 32'(phase), 32'd6);
    check("rev_count", 32'(count), 32'b1100);
    cyc(1, 10, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) cyc(0, 0, 0, 0, 0, 0);
    check("wrap_phase", 32'(phase), 32'd0);
    check("wrap_count", 32'(count), 32'h0);

    // Pause for 3 cycles after the 2nd step
    cyc(1, 4, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("pause_mid_count", 32'(count), 32'b0011);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);
    check("pause_hold_count", 32'(count), 32'b0011);
    k = 5;
    while (!done && k < 30) begin
      cyc(0, 0, 0, 0, 0, 0);
      k++;
    end
    check("pause_done_edge", 32'(k), 32'd7);
    check("pause_final_count", 32'(count), 32'b1111);
    cyc(0, 0, 0, 0, 0, 0);

    // Abort together with pause after 2 of 6 steps
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 6, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    check("abort_count", 32'(count), 32'b0011);
    check("abort_left", 32'(steps_left), 32'd4);
    check("abort_flags", 32'({done, aborted}), 32'b11);
    cyc(0, 0, 0, 0, 1, 0);
    check("abort_idle", 32'({cmd_ready, done}), 32'b10);

    // Abort beats the final step; command accepted with abort high in IDLE
    cyc(1, 1, 0, 0, 1, 0);
    check("abort_idle_accept", 32'(busy), 32'h1);
    cyc(0, 0, 0, 0, 1, 0);
    check("abort_last_left", 32'(steps_left), 32'd1);
    check("abort_last_count", 32'(count), 32'b0011);
    cyc(0, 0, 0, 0, 0, 0);

    // Zero-step command
    cyc(1, 0, 1, 0, 0, 0);
    check("zero_done", 32'(done), 32'h1);
    check("zero_count", 32'(count), 32'b0011);
    cyc(0, 0, 0, 0, 0, 0);

    // Reset mid-run
    cyc(1, 5, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    check("rst_run_state", 32'({count, busy, done, aborted}), 32'h0);
    cyc(0, 0, 0, 0, 0, 0);
    check("rst_run_nodone", 32'(done), 32'h0);

    // Random traffic against the reference
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 2) == 0, $urandom_range(0, 12), $urandom % 2 == 1,
          ($urandom % 4) == 0, ($urandom % 12) == 0, ($urandom % 60) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
